// File: rtl/pipeline_debug_pkg.sv
// rtl/pipeline_debug_pkg.sv - run-control states, host command encodings and halt word
package pipeline_debug_pkg;

    typedef enum logic [2:0] {
        ST_HALTED = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DUMP   = 3'd4
    } seq_state_t;

    localparam logic [2:0] OP_RUN    = 3'd0;
    localparam logic [2:0] OP_STEP   = 3'd1;
    localparam logic [2:0] OP_HALT   = 3'd2;
    localparam logic [2:0] OP_DUMP   = 3'd3;
    localparam logic [2:0] OP_SET_BP = 3'd4;
    localparam logic [2:0] OP_CLR_BP = 3'd5;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/dump_skid_fifo.sv
// rtl/dump_skid_fifo.sv - small valid/ready FIFO absorbing in-flight debug reads under host backpressure
module dump_skid_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [W-1:0]  s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    output logic [W-1:0]  m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign s_tready = (count != CW'(DEPTH));
    assign m_tvalid = (count != '0);
    assign m_tdata  = mem[rd_ptr];
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_tdata;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) rd_ptr <= bump(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_debug_sequencer.sv
// rtl/pipeline_debug_sequencer.sv - pipeline run control (run/step/halt/drain) and halted memory dump
module pipeline_debug_sequencer
    import pipeline_debug_pkg::*;
#(
    parameter int          DRAIN_CYCLES = 3,
    parameter int          MEM_LATENCY  = 1,
    parameter logic [31:0] HALT_WORD    = HALT_WORD_DEFAULT,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [31:0]      cmd_arg,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [31:0]      pc_if,
    input  logic [31:0]      instruction_id,
    output logic             pipe_en,
    output logic             debugMode,
    output logic [31:0]      DebugAddress,
    input  logic [31:0]      dbg_rdata,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [31:0]      dump_data,
    output logic             dump_last,
    output logic             halted,
    output logic [31:0]      cycle_count
);
    localparam int FIFO_DEPTH = MEM_LATENCY + 1;
    localparam int FC_W       = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W      = $clog2(2 * MEM_LATENCY + 2);

    seq_state_t             state, state_next;
    logic [CNT_W-1:0]       cnt, dump_len, issue_cnt, out_cnt;
    logic                   bp_en;
    logic [31:0]            bp_addr;
    logic                   cmd_fire, trigger, issue, rd_valid, fifo_s_ready, last_hs;
    logic [MEM_LATENCY-1:0] pend;
    logic [OCC_W-1:0]       inflight;
    logic [FC_W-1:0]        fifo_count;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign trigger  = (state == ST_RUN) &&
                      ((cmd_fire && cmd_op == OP_HALT) || (bp_en && pc_if == bp_addr) ||
                       instruction_id == HALT_WORD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_HALTED;
            pipe_en <= 1'b0;
        end else begin
            state   <= state_next;
            pipe_en <= state_next inside {ST_RUN, ST_STEP, ST_DRAIN};
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_HALTED: if (cmd_fire) begin
                if (cmd_op == OP_RUN) state_next = ST_RUN;
                else if (cmd_op == OP_STEP) state_next = ST_STEP;
                else if (cmd_op == OP_DUMP && cmd_len != '0) state_next = ST_DUMP;
            end
            ST_RUN:             if (trigger) state_next = ST_DRAIN;
            ST_STEP, ST_DRAIN:  if (cnt <= CNT_W'(1)) state_next = ST_HALTED;
            ST_DUMP:            if (last_hs) state_next = ST_HALTED;
            default:            state_next = ST_HALTED;
        endcase
    end

    always_comb begin
        halted    = (state == ST_HALTED);
        debugMode = (state == ST_DUMP);
        case (state)
            ST_HALTED: cmd_ready = 1'b1;
            ST_RUN:    cmd_ready = cmd_op inside {OP_HALT, OP_SET_BP, OP_CLR_BP};
            default:   cmd_ready = 1'b0;
        endcase
    end

    // Reads in flight plus buffered words never exceed the FIFO depth, so backpressure loses nothing.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) inflight = inflight + OCC_W'(pend[i]);
    end

    assign issue    = (state == ST_DUMP) && (issue_cnt != dump_len) && fifo_s_ready &&
                      (inflight + OCC_W'(fifo_count) <= OCC_W'(MEM_LATENCY));
    assign rd_valid = pend[MEM_LATENCY-1];
    assign last_hs  = dump_valid && dump_ready && (out_cnt == dump_len - CNT_W'(1));
    assign dump_last = dump_valid && (out_cnt == dump_len - CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            bp_en        <= 1'b0;
            bp_addr      <= '0;
            dump_len     <= '0;
            issue_cnt    <= '0;
            out_cnt      <= '0;
            DebugAddress <= '0;
            pend         <= '0;
            cycle_count  <= '0;
        end else begin
            if (state == ST_HALTED && cmd_fire && cmd_op == OP_STEP)
                cnt <= (cmd_arg[CNT_W-1:0] == '0) ? CNT_W'(1) : cmd_arg[CNT_W-1:0];
            else if (trigger)
                cnt <= CNT_W'(DRAIN_CYCLES);
            else if (state inside {ST_STEP, ST_DRAIN})
                cnt <= cnt - CNT_W'(1);

            if (cmd_fire && cmd_op == OP_SET_BP) begin
                bp_en   <= 1'b1;
                bp_addr <= cmd_arg;
            end else if (cmd_fire && cmd_op == OP_CLR_BP) begin
                bp_en   <= 1'b0;
            end

            if (state == ST_HALTED && cmd_fire && cmd_op == OP_DUMP && cmd_len != '0) begin
                dump_len     <= cmd_len;
                issue_cnt    <= '0;
                out_cnt      <= '0;
                DebugAddress <= cmd_arg;
            end else begin
                if (issue) begin
                    issue_cnt <= issue_cnt + CNT_W'(1);
                    // Stay on the final address read rather than stepping past the window.
                    if (issue_cnt != dump_len - CNT_W'(1)) DebugAddress <= DebugAddress + 32'd1;
                end
                if (dump_valid && dump_ready) out_cnt <= out_cnt + CNT_W'(1);
            end

            pend <= (pend << 1) | MEM_LATENCY'(issue);
            if (pipe_en) cycle_count <= cycle_count + 32'd1;
        end
    end

    dump_skid_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH),
        .CW    (FC_W)
    ) u_dump_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_tdata  (dbg_rdata),
        .s_tvalid (rd_valid),
        .s_tready (fifo_s_ready),
        .m_tdata  (dump_data),
        .m_tvalid (dump_valid),
        .m_tready (dump_ready),
        .count    (fifo_count)
    );

endmodule

// File: doc/pipeline_debug_sequencer.md
Name: pipeline_debug_sequencer

Overview:
Run-control sequencer for the 5-stage MIPS Pipeline. It gates the pipeline clock enable and supports free-run, N-cycle single-step, halt on breakpoint or halt instruction, and drain-to-quiescent. When halted, it takes over the data memory debug port and streams a memory window to a host over a valid/ready handshake. It sits between the host command interface (UART bridge) and the Pipeline top.

Parameters:
DRAIN_CYCLES, 3, enable cycles granted after a halt trigger so older instructions retire through EX/MEM/WB
MEM_LATENCY, 1, cycles from DebugAddress to valid dbg_rdata (range 1..3)
HALT_WORD, 32'hFFFF_FFFF, instruction encoding treated as halt when seen in ID
CNT_W, 16, width of the step and dump length counters

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command present
cmd_ready  out  1  command accepted this cycle when high together with cmd_valid
cmd_op  in  3  0=RUN 1=STEP 2=HALT 3=DUMP 4=SET_BP 5=CLR_BP; others ignored but accepted
cmd_arg  in  32  STEP: count[CNT_W-1:0]; DUMP: base address; SET_BP: breakpoint PC
cmd_len  in  CNT_W  DUMP word count
pc_if  in  32  PC_sumado_IF from the pipeline
instruction_id  in  32  instruction_ID from the pipeline
pipe_en  out  1  pipeline clock enable
debugMode  out  1  drives Pipeline debugMode
DebugAddress  out  32  drives Pipeline DebugAddress
dbg_rdata  in  32  memory read data from the debug port
dump_valid  out  1  dump word available
dump_ready  in  1  host accepts dump word
dump_data  out  32  dump word
dump_last  out  1  high with the final dump word
halted  out  1  high in HALTED state
cycle_count  out  32  count of cycles with pipe_en high; wraps

Behaviour:
- Reset values: state=HALTED, pipe_en=0, debugMode=0, DebugAddress=0, dump_valid=0, dump_last=0, dump_data=0, cycle_count=0, bp_en=0, bp_addr=0, halted=1.
- cmd_ready=1 in HALTED. In RUN it is 1 only for HALT, SET_BP and CLR_BP; all other ops are held off (cmd_ready=0). In STEP, DRAIN and DUMP it is 0.
- SET_BP and CLR_BP are accepted in HALTED and RUN and do not change state.
- HALTED + RUN -> RUN. HALTED + STEP -> STEP with counter = count, where count 0 is treated as 1. HALTED + DUMP -> DUMP, or stays in HALTED if cmd_len=0. HALT in HALTED is a no-op.
- RUN: pipe_en=1. A trigger moves to DRAIN on the next edge with the drain counter = DRAIN_CYCLES. Triggers: an accepted HALT, bp_en && pc_if==bp_addr, or instruction_id==HALT_WORD. If several triggers occur in the same cycle, a single DRAIN is entered.
- DRAIN: pipe_en=1 for exactly DRAIN_CYCLES cycles, then HALTED. New triggers are ignored.
- STEP: pipe_en=1 for exactly count cycles, then HALTED. Breakpoints and halt words are ignored during STEP.
- pipe_en is registered. It goes high the cycle after the command is accepted and falls on the edge the count expires.
- DUMP: debugMode=1 for the whole state. DebugAddress starts at base and increments by 1 per issued read. Reads are issued only while the outstanding count plus buffered words is at most MEM_LATENCY.
- DUMP uses an internal skid buffer of depth MEM_LATENCY+1 with no loss under dump_ready backpressure. dump_last marks word cmd_len-1.
- DUMP exits to HALTED on the cycle after the last word handshakes. DebugAddress then holds its value and debugMode drops.
- DebugAddress increments modulo 2^32 (wraps).
- cycle_count increments on every cycle pipe_en=1 and wraps at 2^32.
- Asynchronous reset mid-operation aborts any state immediately to the reset values. A partial dump is discarded.

Decomposition:
- Package pipeline_debug_pkg holds the state enum (HALTED, RUN, STEP, DRAIN, DUMP), the cmd_op encodings and HALT_WORD.
- One sub-module, dump_skid_fifo: a parameterised small FIFO with valid/ready on both sides, instantiated by DUMP.

Test Plan:
- STEP count=5 from reset -> pipe_en high exactly 5 cycles, cycle_count=5, halted=1. STEP count=0 -> exactly 1 cycle.
- SET_BP 0x10, then RUN with pc_if reaching 0x10 on cycle 7 -> pipe_en high 7+3 cycles, then halted=1.
- instruction_id=0xFFFFFFFF in RUN on the same cycle as a HALT command -> single DRAIN of 3 cycles, no second drain.
- DUMP base=0x20 len=4 with dbg_rdata=addr+0x100 and dump_ready toggling 1,0,0,1 -> words 0x120..0x123 in order, dump_last only on 0x123, none dropped or duplicated.
- DUMP base=0xFFFFFFFE len=3 -> DebugAddress sequence FFFFFFFE, FFFFFFFF, 00000000.
- reset_n pulsed low mid-DUMP and mid-RUN -> all outputs return to reset values asynchronously, cmd_ready=1 after release.
